// File: rtl/led_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_controller
// Brief    : Receive-side sequencer for one WS2812-style daisy-chain node:
//            captures the first BITS_PER_LED bits of a frame, then passthrough.
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_controller #(
    parameter int BITS_PER_LED = 24,
    parameter int RESET_CYCLES = 2500,
    parameter int CNT_W        = 12
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_signal_syncd,
    input  logic                    i_rising,
    input  logic                    i_bit_valid,
    input  logic                    i_bit_value,
    output logic                    o_shift_en,
    output logic                    o_shift_bit,
    output logic [BITS_PER_LED-1:0] o_led_data,
    output logic                    o_led_update,
    output logic                    o_passthru_en,
    output logic                    o_frame_err,
    output logic [1:0]              o_state
);

    localparam int                  c_bcnt_w   = $clog2(BITS_PER_LED + 1);
    localparam logic [c_bcnt_w-1:0] c_last_bit = c_bcnt_w'(BITS_PER_LED - 1);
    localparam logic [CNT_W-1:0]    c_gap_full = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0]    c_gap_edge = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_PASSTHRU = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [CNT_W-1:0]          r_low_cnt;
    logic [c_bcnt_w-1:0]       r_bit_cnt;
    logic [BITS_PER_LED-1:0]   r_shadow;
    logic [BITS_PER_LED-1:0]   r_led_data;
    logic                      r_shift_en;
    logic                      r_shift_bit;
    logic                      r_led_update;
    logic                      r_passthru_en;
    logic                      r_frame_err;
    logic                      w_latch;
    logic                      w_accept;
    logic                      w_publish;
    logic                      w_abort;

    // Strobe on the low cycle that carries the counter onto RESET_CYCLES; saturation keeps it one-shot
    assign w_latch = !i_signal_syncd && (r_low_cnt == c_gap_edge);

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_publish    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_latch && (i_rising || i_bit_valid)) begin
                    w_next_state = S_CAPTURE;
                    w_accept     = i_bit_valid;
                end
            end
            S_CAPTURE: begin
                if (w_latch) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (i_bit_valid) begin
                    w_accept = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_next_state = S_PASSTHRU;
                    end
                end
            end
            S_PASSTHRU: begin
                if (w_latch) begin
                    w_publish    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_low_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shadow      <= '0;
            r_led_data    <= '0;
            r_shift_en    <= 1'b0;
            r_shift_bit   <= 1'b0;
            r_led_update  <= 1'b0;
            r_passthru_en <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (i_signal_syncd) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != c_gap_full) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end

            // Shadow and bit count restart whenever the frame closes or is aborted
            if (w_next_state == S_IDLE) begin
                r_bit_cnt <= '0;
                r_shadow  <= '0;
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shadow  <= {r_shadow[BITS_PER_LED-2:0], i_bit_value};
            end

            if (w_publish) begin
                r_led_data <= r_shadow;
            end

            r_shift_en    <= w_accept;
            r_shift_bit   <= w_accept & i_bit_value;
            r_led_update  <= w_publish;
            r_frame_err   <= w_abort;
            r_passthru_en <= (r_state == S_PASSTHRU);
        end
    end

    assign o_shift_en    = r_shift_en;
    assign o_shift_bit   = r_shift_bit;
    assign o_led_data    = r_led_data;
    assign o_led_update  = r_led_update;
    assign o_passthru_en = r_passthru_en;
    assign o_frame_err   = r_frame_err;
    assign o_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_controller
// Brief    : Directed and randomized frames against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_frame_controller;

    localparam int c_gap = 2500;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        signal_syncd;
    logic        rising;
    logic        bit_valid;
    logic        bit_value;
    logic        shift_en;
    logic        shift_bit;
    logic [23:0] led_data;
    logic        led_update;
    logic        passthru_en;
    logic        frame_err;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    // Pulse tallies maintained only by the monitor; directed steps compare deltas
    int          n_shift = 0;
    int          n_upd   = 0;
    int          n_err   = 0;
    logic [23:0] mon_bits = '0;

    logic [23:0] model_led;

    always #5 clk = ~clk;

    led_frame_controller dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_signal_syncd (signal_syncd),
        .i_rising       (rising),
        .i_bit_valid    (bit_valid),
        .i_bit_value    (bit_value),
        .o_shift_en     (shift_en),
        .o_shift_bit    (shift_bit),
        .o_led_data     (led_data),
        .o_led_update   (led_update),
        .o_passthru_en  (passthru_en),
        .o_frame_err    (frame_err),
        .o_state        (state)
    );

    always @(negedge clk) begin
        if (reset_n) begin
            if (shift_en) begin
                n_shift  <= n_shift + 1;
                mon_bits <= {mon_bits[22:0], shift_bit};
            end
            if (led_update) n_upd <= n_upd + 1;
            if (frame_err)  n_err <= n_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        signal_syncd = 1'b0;
        rising       = 1'b0;
        bit_valid    = 1'b0;
        repeat (n) cycle();
    endtask

    // One line bit: 3 high cycles, then 3 low cycles with the decode pulse on the first
    task automatic send_bit(input logic v, input int idx);
        signal_syncd = 1'b1;
        rising       = 1'b1;
        cycle();
        rising = 1'b0;
        cycle();
        cycle();
        signal_syncd = 1'b0;
        bit_valid    = 1'b1;
        bit_value    = v;
        cycle();
        bit_valid = 1'b0;
        bit_value = 1'b0;
        check("shift_en_latency", shift_en, (idx < 24));
        if (idx < 24) check("shift_bit", shift_bit, v);
        check("passthru_1st", passthru_en, (idx >= 24));
        cycle();
        check("passthru_2nd", passthru_en, (idx >= 23));
        cycle();
    endtask

    // Frame model: first 24 bits shift and publish; a short frame only flags an error
    task automatic run_frame(input logic [47:0] bits, input int n);
        int s0;
        int u0;
        int e0;
        int n_exp;
        s0 = n_shift;
        u0 = n_upd;
        e0 = n_err;
        for (int i = 0; i < n; i++) send_bit(bits[47-i], i);
        gap(c_gap + 10);
        n_exp = (n < 24) ? n : 24;
        check("frame_shift_cnt", n_shift - s0, n_exp);
        check("frame_upd_cnt", n_upd - u0, (n >= 24) ? 1 : 0);
        check("frame_err_cnt", n_err - e0, (n < 24) ? 1 : 0);
        if (n >= 24) begin
            model_led = bits[47:24];
            check("frame_shift_bits", mon_bits, model_led);
        end
        check("frame_led_data", led_data, model_led);
        check("frame_state_idle", state, 0);
        check("frame_passthru_off", passthru_en, 0);
    endtask

    initial begin
        logic [63:0] rnd;
        logic [23:0] word;
        int          u0;
        int          e0;
        int          s0;
        int          n;

        reset_n      = 1'b0;
        signal_syncd = 1'b0;
        rising       = 1'b0;
        bit_valid    = 1'b0;
        bit_value    = 1'b0;
        model_led    = '0;
        repeat (3) cycle();
        reset_n = 1'b1;
        cycle();
        check("rst_shift_en", shift_en, 0);
        check("rst_shift_bit", shift_bit, 0);
        check("rst_led_data", led_data, 0);
        check("rst_led_update", led_update, 0);
        check("rst_passthru", passthru_en, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_state", state, 0);
        s0 = n_shift;
        u0 = n_upd;
        e0 = n_err;
        gap(100);
        check("idle_no_pulses", (n_shift - s0) + (n_upd - u0) + (n_err - e0), 0);
        check("idle_state", state, 0);

        run_frame({24'hA5C3F0, 24'h000000}, 24);
        run_frame({24'h123456, 24'hFFFFFF}, 48);
        run_frame({24'h5A5A5A, 24'h000000}, 10);

        // Interrupted gap: 2499 low, a high blip, then the full 2500 low
        word = 24'h3C96E1;
        for (int i = 0; i < 24; i++) send_bit(word[23-i], i);
        u0 = n_upd;
        e0 = n_err;
        gap(c_gap - 4);
        check("gap2499_no_upd", n_upd - u0, 0);
        check("gap2499_state", state, 2);
        signal_syncd = 1'b1;
        rising       = 1'b1;
        cycle();
        gap(c_gap - 1);
        check("gap_restart_no_upd", n_upd - u0, 0);
        cycle();
        check("gap_full_update", led_update, 1);
        check("gap_full_data", led_data, word);
        model_led = word;
        gap(10000);
        check("long_low_one_upd", n_upd - u0, 1);
        check("long_low_no_err", n_err - e0, 0);
        check("long_low_state", state, 0);

        // Reset in the middle of a frame
        word = 24'hC0FFEE;
        for (int i = 0; i < 12; i++) send_bit(word[23-i], i);
        reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        cycle();
        model_led = '0;
        check("midrst_state", state, 0);
        check("midrst_led_data", led_data, 0);
        check("midrst_passthru", passthru_en, 0);
        check("midrst_shift_en", shift_en, 0);
        gap(20);
        run_frame({24'h0F1E2D, 24'h000000}, 24);

        for (int f = 0; f < 4; f++) begin
            rnd = {$urandom(), $urandom()};
            n   = (f % 2 == 0) ? (24 + $urandom_range(0, 8)) : $urandom_range(1, 23);
            run_frame(rnd[47:0], n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
